// File: rtl/fifo_tb_pkg.sv
// Types and constants shared by the FIFO traffic generator and the read-side checker.
package fifo_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } rc_state_t;

    // Width of the incrementing test pattern produced by the write-side generator.
    localparam int PAT_W = 5;

endpackage

// File: rtl/recv_check_if.sv
// Read port of the async FIFO as seen from the rclk domain.
interface recv_check_if #(
    parameter int D_SIZE = 8
) ();

    logic              ren;
    logic              empty;
    logic [D_SIZE-1:0] rdata;

    // master: the consumer issuing reads; slave: the FIFO answering them.
    modport master (output ren, input empty, input rdata);
    modport slave  (input ren, output empty, output rdata);

endinterface

// File: rtl/pat_check.sv
// Incrementing-pattern checker: expect counter with resync on mismatch,
// saturating read/error counters and sticky first-error capture.
module pat_check #(
    parameter int D_SIZE    = 8,
    parameter int CNT_W     = 5,
    parameter int CNT_OUT_W = 16
) (
    input  logic                 rclk,
    input  logic                 rstn,
    input  logic                 i_valid,
    input  logic                 i_clr,
    input  logic [D_SIZE-1:0]    i_data,
    output logic                 o_mismatch,
    output logic [CNT_OUT_W-1:0] o_rd_cnt,
    output logic [CNT_OUT_W-1:0] o_err_cnt,
    output logic                 o_error,
    output logic [D_SIZE-1:0]    o_first_bad
);

    logic [CNT_W-1:0]     r_expect;
    logic [CNT_OUT_W-1:0] r_rd_cnt;
    logic [CNT_OUT_W-1:0] r_err_cnt;
    logic                 r_error;
    logic [D_SIZE-1:0]    r_first_bad;
    logic [D_SIZE-1:0]    w_expected;
    logic                 w_match;

    // Upper bits of the expected word are zero, so any set upper bit mismatches.
    assign w_expected = D_SIZE'(r_expect);
    assign w_match    = (i_data == w_expected);
    assign o_mismatch = i_valid & ~i_clr & ~w_match;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_expect    <= '0;
            r_rd_cnt    <= '0;
            r_err_cnt   <= '0;
            r_error     <= 1'b0;
            r_first_bad <= '0;
        end else if (i_clr) begin
            r_expect    <= '0;
            r_rd_cnt    <= '0;
            r_err_cnt   <= '0;
            r_error     <= 1'b0;
            r_first_bad <= '0;
        end else if (i_valid) begin
            if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_OUT_W'(1);
            if (w_match) begin
                r_expect <= r_expect + CNT_W'(1);
            end else begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_OUT_W'(1);
                r_error <= 1'b1;
                if (!r_error) r_first_bad <= i_data;
                // Resync on the received word so a single dropped word costs one error.
                r_expect <= i_data[CNT_W-1:0] + CNT_W'(1);
            end
        end
    end

    assign o_rd_cnt    = r_rd_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_error     = r_error;
    assign o_first_bad = r_first_bad;

endmodule

// File: rtl/recv_check.sv
// Read-side traffic consumer for the async FIFO: drains it while enabled and
// hands each returned word to pat_check one cycle after the accepted read.
module recv_check
    import fifo_tb_pkg::*;
#(
    parameter int D_SIZE      = 8,
    parameter int CNT_W       = PAT_W,
    parameter int CNT_OUT_W   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 rclk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 hold,
    input  logic                 clr,
    recv_check_if.master         rd,
    output logic [CNT_OUT_W-1:0] rd_cnt,
    output logic [CNT_OUT_W-1:0] err_cnt,
    output logic                 error,
    output logic [D_SIZE-1:0]    first_bad,
    output logic                 halted
);

    rc_state_t r_state;
    rc_state_t w_next_state;
    logic      r_ren;
    logic      r_rvalid;
    logic      w_ren_next;
    logic      w_mismatch;

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (en) w_next_state = RUN;
            // Dropping en wins over a simultaneous mismatch; the error is still recorded.
            RUN: begin
                if (!en)                              w_next_state = IDLE;
                else if (STOP_ON_ERR && w_mismatch)   w_next_state = HALT;
            end
            HALT: if (clr) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ren_next = (r_state == RUN) & en & ~hold & ~rd.empty;
        halted     = (r_state == HALT);
    end

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_ren    <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_ren    <= w_ren_next;
            r_rvalid <= r_ren & ~rd.empty;
        end
    end

    assign rd.ren = r_ren;

    pat_check #(
        .D_SIZE    (D_SIZE),
        .CNT_W     (CNT_W),
        .CNT_OUT_W (CNT_OUT_W)
    ) u_pat_check (
        .rclk        (rclk),
        .rstn        (rstn),
        .i_valid     (r_rvalid),
        .i_clr       (clr),
        .i_data      (rd.rdata),
        .o_mismatch  (w_mismatch),
        .o_rd_cnt    (rd_cnt),
        .o_err_cnt   (err_cnt),
        .o_error     (error),
        .o_first_bad (first_bad)
    );

endmodule
